// File: rtl/refresh_scheduler_pkg.sv
// ============================================================================
// Module   : refresh_scheduler_pkg
// Purpose  : Shared DRAM cycle constants, refresh FSM state type and helpers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package refresh_scheduler_pkg;

    localparam int CYCLE_TRP   = 12;
    localparam int CYCLE_TRCD  = 12;
    localparam int CYCLE_TREFI = 6240;
    localparam int CYCLE_TRFC  = 208;

    localparam int PEND_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_REQ  = 2'd2,
        S_TRFC = 2'd3
    } refresh_state_t;

    function automatic logic [PEND_W-1:0] sat_inc(input logic [PEND_W-1:0] v,
                                                  input logic [PEND_W-1:0] lim);
        return (v >= lim) ? lim : v + PEND_W'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/refresh_scheduler_if.sv
// ============================================================================
// Module   : refresh_scheduler_if
// Purpose  : Handshake bundle between the refresh scheduler and command FSM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface refresh_scheduler_if;
    import refresh_scheduler_pkg::*;

    logic              ref_en;
    logic              host_idle;
    logic              all_banks_idle;
    logic              ref_ack;
    logic              prea_req;
    logic              ref_req;
    logic              refresh_flag;
    logic              urgent;
    logic              ref_busy;
    logic [PEND_W-1:0] pending_cnt;
    logic              ref_overflow;

    // master = command FSM side, slave = the scheduler itself
    modport master (
        output ref_en, host_idle, all_banks_idle, ref_ack,
        input  prea_req, ref_req, refresh_flag, urgent, ref_busy,
               pending_cnt, ref_overflow
    );

    modport slave (
        input  ref_en, host_idle, all_banks_idle, ref_ack,
        output prea_req, ref_req, refresh_flag, urgent, ref_busy,
               pending_cnt, ref_overflow
    );

endinterface

`default_nettype wire

// File: rtl/refresh_scheduler_down_counter.sv
// ============================================================================
// Module   : refresh_down_counter
// Purpose  : Loadable down counter that stops at zero and flags it.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module refresh_down_counter #(
    parameter int WIDTH       = 16,
    parameter int LOAD_VALUE  = 1,
    parameter int RESET_VALUE = 0
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic load,
    input  wire logic en,
    output logic      zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // load has priority so a reload at zero starts the next period seamlessly
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = WIDTH'(LOAD_VALUE);
        end else if (en && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= WIDTH'(RESET_VALUE);
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/refresh_scheduler.sv
// ============================================================================
// Module   : refresh_scheduler
// Purpose  : Per-rank auto-refresh scheduler (tREFI cadence, postponement,
//            prepare/request/tRFC handshake). Define REF_BURST_EN to drain
//            the backlog back-to-back from tRFC straight into the next REF.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module refresh_scheduler
    import refresh_scheduler_pkg::*;
#(
    parameter int TREFI_CYCLES  = CYCLE_TREFI,
    parameter int TRFC_CYCLES   = CYCLE_TRFC,
    parameter int MAX_POSTPONE  = 8,
    parameter int URGENT_THRESH = 6
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    refresh_scheduler_if.slave bus
);

    refresh_state_t    state_q, state_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              refresh_flag_q, refresh_flag_d;
    logic              urgent_q, urgent_d;
    logic              overflow_q, overflow_d;

    logic trefi_zero;
    logic trfc_zero;
    logic tick;
    logic dec;

    assign tick = bus.ref_en && trefi_zero;
    assign dec  = (state_q == S_REQ) && bus.ref_ack;

    refresh_down_counter #(
        .WIDTH       (16),
        .LOAD_VALUE  (TREFI_CYCLES - 1),
        .RESET_VALUE (TREFI_CYCLES - 1)
    ) u_trefi (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tick),
        .en    (bus.ref_en),
        .zero  (trefi_zero)
    );

    refresh_down_counter #(
        .WIDTH       (10),
        .LOAD_VALUE  (TRFC_CYCLES - 1),
        .RESET_VALUE (0)
    ) u_trfc (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (dec),
        .en    (state_q == S_TRFC),
        .zero  (trfc_zero)
    );

    // Flags are registered from the next count so they line up with pending_q.
    always_comb begin
        pending_d  = pending_q;
        overflow_d = overflow_q;
        if (tick && !dec) begin
            pending_d = sat_inc(pending_q, PEND_W'(MAX_POSTPONE));
            if (pending_q == PEND_W'(MAX_POSTPONE)) begin
                overflow_d = 1'b1;
            end
        end else if (dec && !tick) begin
            pending_d = pending_q - PEND_W'(1);
        end
        refresh_flag_d = (pending_d != '0);
        urgent_d       = (pending_d >= PEND_W'(URGENT_THRESH));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if ((pending_q != '0) && (urgent_q || bus.host_idle)) begin
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                if (bus.all_banks_idle) begin
                    state_d = S_REQ;
                end else if (!urgent_q && !bus.host_idle) begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (bus.ref_ack) begin
                    state_d = S_TRFC;
                end
            end
            S_TRFC: begin
                if (trfc_zero) begin
`ifdef REF_BURST_EN
                    // banks are still precharged, so skip the prepare step
                    if ((pending_q != '0) && (urgent_q || bus.host_idle)) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_IDLE;
                    end
`else
                    state_d = S_IDLE;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            pending_q      <= '0;
            refresh_flag_q <= 1'b0;
            urgent_q       <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            refresh_flag_q <= refresh_flag_d;
            urgent_q       <= urgent_d;
            overflow_q     <= overflow_d;
        end
    end

    assign bus.prea_req     = (state_q == S_PREP);
    assign bus.ref_req      = (state_q == S_REQ);
    assign bus.ref_busy     = (state_q == S_TRFC);
    assign bus.pending_cnt  = pending_q;
    assign bus.refresh_flag = refresh_flag_q;
    assign bus.urgent       = urgent_q;
    assign bus.ref_overflow = overflow_q;

endmodule

`default_nettype wire

// File: doc/refresh_scheduler.md
Name: refresh_scheduler

Overview:
Per-rank auto-refresh scheduler that sits directly upstream of the per-bank timing counters and the bank FSM.
- Generates the tREFI cadence and tracks postponed refreshes.
- Drives refresh_flag, which the bank timing counters use to select precharge-to-refresh instead of precharge-to-active recoding.
- Runs the prepare / request / tRFC handshake with the command FSM: opportunistic when the host is idle, forced when the backlog is urgent.

Parameters:
TREFI_CYCLES, 6240, refresh interval in clk cycles (16-bit counter)
TRFC_CYCLES, 208, refresh-to-any-command time in clk cycles (10-bit counter)
MAX_POSTPONE, 8, saturation limit of the pending-refresh count (4-bit)
URGENT_THRESH, 6, pending count at or above which refresh is forced

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ref_en  in  1  enables the tREFI timer
host_idle  in  1  no queued host requests this cycle
all_banks_idle  in  1  all banks precharged and all per-bank timers at 0
ref_ack  in  1  command FSM issues REF this cycle
prea_req  out  1  request precharge-all
ref_req  out  1  request REF command
refresh_flag  out  1  pending_cnt != 0
urgent  out  1  pending_cnt >= URGENT_THRESH
ref_busy  out  1  tRFC window active
pending_cnt  out  4  postponed refresh count
ref_overflow  out  1  sticky: tick lost at saturation

Behaviour:
Reset (asynchronous, rst_n low): immediate effect, including mid-refresh.
- All outputs 0; state S_IDLE.
- tREFI timer = TREFI_CYCLES-1; tRFC timer = 0.

tREFI timer:
- Decrements while ref_en=1; holds while ref_en=0.
- At 0 it produces a 1-cycle tick and reloads TREFI_CYCLES-1. Tick period is exactly TREFI_CYCLES cycles.

pending_cnt update, per cycle (dec = ref_ack accepted in S_REQ):
- tick & !dec: +1, saturating at MAX_POSTPONE. A tick at saturation sets ref_overflow, which clears only on reset.
- dec & !tick: -1.
- tick & dec: unchanged.
- pending_cnt never underflows, because ref_req requires pending_cnt != 0.

Registered flags:
- refresh_flag and urgent are registered and derived from the next value of pending_cnt.
- They are therefore valid in the same cycle pending_cnt changes.

FSM (refresh_state_t): S_IDLE, S_PREP, S_REQ, S_TRFC.
- S_IDLE → S_PREP when pending_cnt != 0 and (urgent or host_idle).
- S_PREP: prea_req=1.
  - → S_REQ when all_banks_idle.
  - → S_IDLE (abort) when !urgent and !host_idle and !all_banks_idle.
  - If all_banks_idle and abort conditions coincide, S_REQ wins.
- S_REQ: ref_req=1 and held until ref_ack.
  - No abort: the command FSM must complete the request.
  - On ref_ack: pending_cnt decrements, tRFC timer loads TRFC_CYCLES-1, → S_TRFC.
- S_TRFC: ref_busy=1; tRFC timer decrements.
  - → S_IDLE in the cycle after the timer reads 0.
  - ref_busy is high for exactly TRFC_CYCLES cycles.

Output and input rules:
- prea_req, ref_req and ref_busy are Moore outputs of the registered state; they are mutually exclusive.
- ref_ack outside S_REQ is ignored.
- ref_en=0 does not abort an in-flight refresh; pending refreshes still drain.

Optional Feature:
REF_BURST_EN
- Defined: in S_TRFC at expiry, if pending_cnt != 0 and (urgent or host_idle), go directly to S_REQ. Banks remain idle, so S_PREP is skipped and the backlog drains back-to-back.
- Not defined: S_TRFC always returns to S_IDLE.

Decomposition:
- Package usertype:
  - refresh_state_t enum, 2-bit.
  - Default cycle constants CYCLE_TREFI and CYCLE_TRFC, placed next to the existing CYCLE_TRP and CYCLE_TRCD.
- One natural sub-module, refresh_down_counter: parameterised width, load value, enable, zero flag.
  - Instantiated twice: tREFI timer and tRFC timer.
- FSM and pending logic stay in the top module.

Test Plan:
Sim parameters: TREFI=100, TRFC=10, MAX=8, THRESH=6.
1. Reset; ref_en=1, host_idle=1, all_banks_idle=1, ack one cycle after ref_req.
   - First tick at cycle 100; pending_cnt=1 and refresh_flag=1.
   - prea_req 1 cycle, then ref_req; after ack pending_cnt=0 and ref_busy high for exactly 10 cycles.
2. host_idle=0 for 650 cycles.
   - pending_cnt climbs to 6; urgent=1 at cycle 600; prea_req asserted despite host_idle=0.
3. Drive the 650-cycle host_idle=0 build-up of scenario 2, but hold all_banks_idle=0 and never ack.
   - pending saturates at 8 at cycle 800; ref_overflow=1 at the cycle-900 tick, and stays set.
4. In S_PREP with pending=1 (not urgent): drop host_idle, hold all_banks_idle=0.
   - Abort to S_IDLE next cycle; prea_req=0; pending still 1.
5. Align ref_ack with a tick while pending=2.
   - pending stays 2; refresh_flag stays 1.
6. Assert rst_n low during S_TRFC.
   - All outputs 0 immediately; after release, first tick occurs 100 cycles later.
   - With REF_BURST_EN and pending=3: three REFs issued with no prea_req between them.
